time_keeper: RTL and testbench
==============================

TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, clk cycles per second.
REQ-002 SHALL have parameter REPEAT_DELAY, default 50000000, held-increment cycles before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 10000000, cycles between auto-repeat steps.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset_n  input  1  reset; one clock, asynchronous, active-low.
REQ-006 run  input  1  1 = time advances; 0 = prescaler frozen.
REQ-007 select  input  2  field to edit, using the shared SELECT_SEC/SELECT_MIN/SELECT_HOUR codes; the fourth code edits nothing.
REQ-008 increment  input  2-state level  1  user step request, synchronous to clk.
REQ-009 sec  output  6  seconds 0..59, registered.
REQ-010 min  output  6  minutes 0..59, registered.
REQ-011 hour  output  5  hours 0..23, registered.
REQ-012 tick  output  1  one-cycle pulse, registered, high in the first cycle sec shows the tick-advanced value.

Function
REQ-013 Prescaler SHALL count 0..CLK_FREQ-1 while run=1, hold while run=0, wrap to 0 at CLK_FREQ-1 and raise tick on that wrap edge.
REQ-014 On tick, sec SHALL advance: 59->0 carries into min; min 59->0 carries into hour; hour 23->0; 23:59:59 -> 00:00:00 in one edge.
REQ-015 Edit step SHALL occur on an increment rising edge (registered previous value, 1-cycle latency: outputs change on the edge after the 0->1 sample).
REQ-016 Edit step SHALL add 1 to the selected field only, wrapping 59->0 (sec, min) or 23->0 (hour), never carrying.
REQ-017 Edit step on SELECT_SEC SHALL also clear the prescaler to 0.
REQ-018 If a tick and an edit step fall on the same edge, the edit SHALL win and that tick SHALL be dropped entirely (no field advance, tick output low).
REQ-019 Edits SHALL be accepted regardless of run.
REQ-020 Changing select while increment is held SHALL NOT produce a step.
REQ-021 Width rule: wrap comparisons SHALL use the field's current value (e.g. sec==59), never an overflowed sum.

Reset
REQ-022 reset_n low SHALL immediately force sec=0, min=0, hour=0, tick=0, prescaler=0, previous-increment=0, repeat counter=0.
REQ-023 Reset asserted mid-edit or mid-repeat SHALL abort it; after release, a still-high increment SHALL NOT step until it falls and rises again.

Configuration
REQ-024 Macro TIME_KEEPER_AUTO_REPEAT_EN: when defined, increment held high for REPEAT_DELAY cycles after its rising edge SHALL produce one extra step, then one step every REPEAT_PERIOD cycles until increment falls; falling edge resets the repeat counter.
REQ-025 When TIME_KEEPER_AUTO_REPEAT_EN is undefined, only rising edges step and no repeat counter SHALL be synthesised.
REQ-026 Auto-repeat steps SHALL obey REQ-016..REQ-018 identically to edge steps.

Structure
REQ-027 SELECT_SEC/SELECT_MIN/SELECT_HOUR SHALL come from the shared constants header; no local redefinition.
REQ-028 Field maxima (59, 23) SHALL be defined as shared constants in that header.
REQ-029 Prescaler SHALL be a sub-module tick_gen (ports clk, reset_n, enable, clear, tick; parameter CLK_FREQ).

Verification (CLK_FREQ=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-030 Reset release, run=1 for 16 cycles -> tick every 4th cycle, sec=4, min=0, hour=0.
REQ-031 Set 23:59:59 via edits, run one tick -> 00:00:00, tick=1 for exactly one cycle.
REQ-032 select=SELECT_MIN, min=59, one increment pulse -> min=0, hour unchanged, sec unchanged.
REQ-033 Increment edge (SELECT_HOUR) coincident with prescaler wrap -> hour+1, sec unchanged, tick stays 0.
REQ-034 SELECT_SEC edit at prescaler=2 -> sec+1, next tick exactly 4 cycles later.
REQ-035 With TIME_KEEPER_AUTO_REPEAT_EN, increment held 15 cycles on SELECT_MIN from 0 -> min=4 (edge, +8, +11, +14); without macro -> min=1.

Source files
------------

// File: rtl/time_keeper_pkg.sv
// time_keeper_pkg: shared select codes and field maxima for the time keeper
package time_keeper_pkg;

   typedef enum logic [1:0] {
      SELECT_SEC  = 2'd0,
      SELECT_MIN  = 2'd1,
      SELECT_HOUR = 2'd2,
      SELECT_NONE = 2'd3
   } select_t;

   localparam logic [5:0] SEC_MAX  = 6'd59;
   localparam logic [5:0] MIN_MAX  = 6'd59;
   localparam logic [4:0] HOUR_MAX = 5'd23;

endpackage

// File: rtl/time_keeper_tick_gen.sv
// tick_gen: free-running prescaler, tick is high in the cycle the count wraps
module tick_gen #(
   parameter int CLK_FREQ = 100000000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int W = CLK_FREQ > 1 ? $clog2(CLK_FREQ) : 1;

   logic [W-1:0] count;

   assign tick = enable && count == W'(CLK_FREQ - 1);

   // count while enabled, wrap on tick, clear on request
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         count <= '0;
      else if (clear || tick)
         count <= '0;
      else if (enable)
         count <= count + W'(1);

endmodule

// File: rtl/time_keeper.sv
// time_keeper: hh:mm:ss clock with per-field edit; TIME_KEEPER_AUTO_REPEAT_EN adds held-key auto-repeat
module time_keeper #(
   parameter int CLK_FREQ      = 100000000,
   parameter int REPEAT_DELAY  = 50000000,
   parameter int REPEAT_PERIOD = 10000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       run,
   input  logic [1:0] select,
   input  logic       increment,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic [4:0] hour,
   output logic       tick
);

   import time_keeper_pkg::*;

   if (CLK_FREQ < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("time_keeper: CLK_FREQ, REPEAT_DELAY and REPEAT_PERIOD must be positive");
   end

   logic       prev_inc;
   logic       armed;
   logic       inc_edge;
   logic       step;
   logic       edit;
   logic       wrap;
   logic [5:0] sec_inc, min_inc, sec_nxt, min_nxt;
   logic [4:0] hour_inc, hour_nxt;

   assign inc_edge = increment && !prev_inc && armed;
   assign edit     = step && select != SELECT_NONE;

   tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (run),
      .clear   (edit && select == SELECT_SEC),
      .tick    (wrap)
   );

   // edge detector; armed stays low after reset until increment has been seen low
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         prev_inc <= 1'b0;
         armed    <= 1'b0;
      end else begin
         prev_inc <= increment;
         armed    <= armed | ~increment;
      end

`ifdef TIME_KEEPER_AUTO_REPEAT_EN
   localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);

   logic [RW-1:0] rep_cnt;
   logic          rep_phase;
   logic          rep_hit;

   assign rep_hit = increment && rep_cnt != '0 &&
                    rep_cnt == (rep_phase ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY));
   assign step    = inc_edge | rep_hit;

   // cycles held since the last step; first target is the delay, then the period
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         rep_cnt   <= '0;
         rep_phase <= 1'b0;
      end else if (!increment) begin
         rep_cnt   <= '0;
         rep_phase <= 1'b0;
      end else if (inc_edge || rep_hit) begin
         rep_cnt   <= RW'(1);
         rep_phase <= rep_hit;
      end else if (rep_cnt != '0)
         rep_cnt <= rep_cnt + RW'(1);
`else
   assign step = inc_edge;
`endif

   // next field values: an edit bumps one field without carry and beats a tick
   always_comb begin
      sec_inc  = (sec == SEC_MAX) ? 6'd0 : sec + 6'd1;
      min_inc  = (min == MIN_MAX) ? 6'd0 : min + 6'd1;
      hour_inc = (hour == HOUR_MAX) ? 5'd0 : hour + 5'd1;
      sec_nxt  = edit ? (select == SELECT_SEC ? sec_inc : sec) : wrap ? sec_inc : sec;
      min_nxt  = edit ? (select == SELECT_MIN ? min_inc : min)
                      : (wrap && sec == SEC_MAX) ? min_inc : min;
      hour_nxt = edit ? (select == SELECT_HOUR ? hour_inc : hour)
                      : (wrap && sec == SEC_MAX && min == MIN_MAX) ? hour_inc : hour;
   end

   // time registers and the registered tick pulse
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         sec  <= '0;
         min  <= '0;
         hour <= '0;
         tick <= 1'b0;
      end else begin
         sec  <= sec_nxt;
         min  <= min_nxt;
         hour <= hour_nxt;
         tick <= wrap && !edit;
      end

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: randomized and directed checks of time_keeper against a seconds-of-day model
module tb_time_keeper;

   import time_keeper_pkg::*;

   localparam int CF = 4;
   localparam int RD = 8;
   localparam int RP = 3;
`ifdef TIME_KEEPER_AUTO_REPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       run = 1'b0;
   logic [1:0] select = 2'd0;
   logic       increment = 1'b0;
   logic [5:0] sec, min;
   logic [4:0] hour;
   logic       tick;

   int tests = 0;
   int fails = 0;

   int m_t, m_phase, m_hold;
   bit m_armed, m_tick;

   always #5 clk = ~clk;

   time_keeper #(.CLK_FREQ(CF), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
      .clk(clk), .reset_n(reset_n), .run(run), .select(select), .increment(increment),
      .sec(sec), .min(min), .hour(hour), .tick(tick)
   );

   function automatic int f_sec();  return m_t % 60;        endfunction
   function automatic int f_min();  return (m_t / 60) % 60; endfunction
   function automatic int f_hour(); return m_t / 3600;      endfunction

   function automatic logic [17:0] exp_state();
      return {5'(f_hour()), 6'(f_min()), 6'(f_sec()), m_tick};
   endfunction

   function automatic int field(input logic [1:0] s);
      return s == SELECT_SEC ? f_sec() : s == SELECT_MIN ? f_min() : f_hour();
   endfunction

   task automatic model_reset();
      m_t = 0; m_phase = 0; m_hold = 0; m_armed = 0; m_tick = 0;
   endtask

   // time as seconds-of-day; a step is the first held cycle or a repeat slot
   task automatic model_edge(input bit r, input logic [1:0] s, input bit inc);
      int k, hs, mi, se;
      bit step, wrap;
      if (!inc) begin m_hold = 0; m_armed = 1; end
      else if (m_hold > 0) m_hold++;
      else if (m_armed) m_hold = 1;
      k = m_hold - 1;
      step = m_hold > 0 && (k == 0 || (AR && k >= RD && (k - RD) % RP == 0)) && s != SELECT_NONE;
      wrap = r && m_phase == CF - 1;
      if (step) begin
         hs = f_hour(); mi = f_min(); se = f_sec();
         if (s == SELECT_SEC) se = (se + 1) % 60;
         if (s == SELECT_MIN) mi = (mi + 1) % 60;
         if (s == SELECT_HOUR) hs = (hs + 1) % 24;
         m_t = hs * 3600 + mi * 60 + se;
         m_tick = 0;
      end else if (wrap) begin
         m_t = (m_t + 1) % 86400;
         m_tick = 1;
      end else m_tick = 0;
      m_phase = (step && s == SELECT_SEC) ? 0 : r ? (m_phase + 1) % CF : m_phase;
   endtask

   task automatic drive(input bit r, input logic [1:0] s, input bit inc);
      run = r; select = s; increment = inc;
      @(posedge clk);
      model_edge(r, s, inc);
      @(negedge clk);
   endtask

   task automatic pulse(input logic [1:0] s);
      drive(0, s, 1);
      drive(0, s, 0);
   endtask

   task automatic set_field(input logic [1:0] s, input int target);
      for (int i = 0; i < 60 && field(s) != target; i++) pulse(s);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      drive(0, SELECT_HOUR, 1);
      drive(0, SELECT_HOUR, 0);
      drive(1, SELECT_HOUR, 1);
      drive(1, SELECT_HOUR, 1);
      reset_n = 1'b0;
      #2;
      tests++;
      if ({hour, min, sec, tick} !== 18'd0) begin
         fails++; $display("FAIL reset_async got %h:%h:%h t%b want zero", hour, min, sec, tick);
      end
      reset_n = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) drive(1, SELECT_HOUR, 1);
      tests++;
      if (hour !== 5'd0) begin
         fails++; $display("FAIL reset_held_inc hour got %0d want 0", hour);
      end
      drive(1, SELECT_HOUR, 0);
      drive(0, SELECT_HOUR, 1);
      tests++;
      if (hour !== 5'd1 || {hour, min, sec, tick} !== exp_state()) begin
         fails++; $display("FAIL reset_rearm got %h want %h", {hour, min, sec, tick}, exp_state());
      end
      drive(0, SELECT_HOUR, 0);
   endtask

   task automatic test_run();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1, SELECT_SEC, 0);
         tests++;
         if (tick !== (i % 4 == 3) || {hour, min, sec, tick} !== exp_state()) begin
            fails++; $display("FAIL run_cycle%0d got %h want %h", i, {hour, min, sec, tick}, exp_state());
         end
      end
      tests++;
      if (sec !== 6'd4 || min !== 6'd0 || hour !== 5'd0) begin
         fails++; $display("FAIL run_16 got %0d:%0d:%0d want 0:0:4", hour, min, sec);
      end
   endtask

   task automatic test_rollover();
      set_field(SELECT_HOUR, 23);
      set_field(SELECT_MIN, 59);
      set_field(SELECT_SEC, 59);
      tests++;
      if (hour !== 5'd23 || min !== 6'd59 || sec !== 6'd59) begin
         fails++; $display("FAIL set_235959 got %0d:%0d:%0d want 23:59:59", hour, min, sec);
      end
      for (int i = 0; i < 3; i++) drive(1, SELECT_SEC, 0);
      tests++;
      if (tick !== 1'b0 || sec !== 6'd59) begin
         fails++; $display("FAIL pre_roll got sec %0d tick %b want 59 0", sec, tick);
      end
      drive(1, SELECT_SEC, 0);
      tests++;
      if ({hour, min, sec, tick} !== 18'd1) begin
         fails++; $display("FAIL rollover got %0d:%0d:%0d t%b want 0:0:0 t1", hour, min, sec, tick);
      end
      drive(0, SELECT_SEC, 0);
      tests++;
      if (tick !== 1'b0) begin
         fails++; $display("FAIL tick_width got %b want 0", tick);
      end
   endtask

   task automatic test_min_wrap();
      int h, s;
      set_field(SELECT_HOUR, $urandom_range(1, 22));
      set_field(SELECT_SEC, $urandom_range(1, 58));
      set_field(SELECT_MIN, 59);
      h = f_hour(); s = f_sec();
      pulse(SELECT_MIN);
      tests++;
      if (min !== 6'd0 || hour !== 5'(h) || sec !== 6'(s)) begin
         fails++; $display("FAIL min_wrap got %0d:%0d:%0d want %0d:0:%0d", hour, min, sec, h, s);
      end
   endtask

   task automatic test_coincide();
      int h, s;
      for (int i = 0; i < 8 && m_phase != CF - 1; i++) drive(1, SELECT_SEC, 0);
      h = f_hour(); s = f_sec();
      drive(1, SELECT_HOUR, 1);
      tests++;
      if (hour !== 5'((h + 1) % 24) || sec !== 6'(s) || tick !== 1'b0) begin
         fails++; $display("FAIL coincide got h%0d s%0d t%b want h%0d s%0d t0", hour, sec, tick, (h + 1) % 24, s);
      end
      drive(1, SELECT_HOUR, 0);
      tests++;
      if (tick !== 1'b0 || {hour, min, sec, tick} !== exp_state()) begin
         fails++; $display("FAIL coincide_after got %h want %h", {hour, min, sec, tick}, exp_state());
      end
   endtask

   task automatic test_sec_clear();
      int s, n;
      for (int i = 0; i < 8 && m_phase != 2; i++) drive(1, SELECT_MIN, 0);
      s = f_sec();
      drive(1, SELECT_SEC, 1);
      tests++;
      if (sec !== 6'((s + 1) % 60)) begin
         fails++; $display("FAIL sec_edit got %0d want %0d", sec, (s + 1) % 60);
      end
      n = 0;
      do begin drive(1, SELECT_SEC, 0); n++; end while (tick !== 1'b1 && n < 20);
      tests++;
      if (n != 4) begin
         fails++; $display("FAIL sec_clear_gap got %0d cycles want 4", n);
      end
   endtask

   task automatic test_select_change();
      int m, h, s;
      drive(0, SELECT_MIN, 0);
      drive(0, SELECT_MIN, 1);
      m = f_min(); h = f_hour(); s = f_sec();
      drive(0, SELECT_HOUR, 1);
      drive(0, SELECT_SEC, 1);
      tests++;
      if (min !== 6'(m) || hour !== 5'(h) || sec !== 6'(s)) begin
         fails++; $display("FAIL select_change got %0d:%0d:%0d want %0d:%0d:%0d", hour, min, sec, h, m, s);
      end
      drive(0, SELECT_SEC, 0);
   endtask

   task automatic test_repeat();
      set_field(SELECT_MIN, 0);
      for (int i = 0; i < 15; i++) begin
         drive(0, SELECT_MIN, 1);
         tests++;
         if ({hour, min, sec, tick} !== exp_state()) begin
            fails++; $display("FAIL repeat_cycle%0d got %h want %h", i, {hour, min, sec, tick}, exp_state());
         end
      end
      drive(0, SELECT_MIN, 0);
      tests++;
      if (min !== (AR ? 6'd4 : 6'd1)) begin
         fails++; $display("FAIL repeat_15 got min %0d want %0d", min, AR ? 4 : 1);
      end
   endtask

   task automatic test_random();
      bit inc = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         if ($urandom_range(0, 9) == 0) inc = ~inc;
         drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), inc);
         tests++;
         if ({hour, min, sec, tick} !== exp_state()) begin
            fails++; $display("FAIL random_cycle%0d got %h want %h", i, {hour, min, sec, tick}, exp_state());
         end
      end
      drive(0, SELECT_SEC, 0);
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      test_reset();
      test_run();
      test_rollover();
      test_min_wrap();
      test_coincide();
      test_sec_clear();
      test_select_change();
      test_repeat();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
